// File: rtl/r2rv_pkg.sv
// Shared types and constants for the rename/reservation-station slice.
// Entry fields are sized by the constants below.
package r2rv_pkg;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned OP_W  = 10;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] tag;
  } rs_entry_t;

  // Op encodings {funct3, funct7} shared with the decoder.
  localparam logic [OP_W-1:0] OP_ADD  = {3'b000, 7'b0000000};
  localparam logic [OP_W-1:0] OP_SUB  = {3'b000, 7'b0100000};
  localparam logic [OP_W-1:0] OP_SLL  = {3'b001, 7'b0000000};
  localparam logic [OP_W-1:0] OP_SLT  = {3'b010, 7'b0000000};
  localparam logic [OP_W-1:0] OP_XOR  = {3'b100, 7'b0000000};
  localparam logic [OP_W-1:0] OP_SRL  = {3'b101, 7'b0000000};
  localparam logic [OP_W-1:0] OP_SRA  = {3'b101, 7'b0100000};
  localparam logic [OP_W-1:0] OP_OR   = {3'b110, 7'b0000000};
  localparam logic [OP_W-1:0] OP_AND  = {3'b111, 7'b0000000};

  // Tag 0 never matches: it marks an operand already present in V.
  function automatic logic tag_hit(input logic vld, input logic [TAG_W-1:0] q,
                                   input logic [TAG_W-1:0] bus_tag);
    return vld && (q != '0) && (q == bus_tag);
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest ready entry using an age matrix (older[i][j] = i older than j).
module rs_oldest_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic                        valid
);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) begin
          grant[i] = 1'b0;
        end
      end
    end
    valid = |ready;
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers dispatched ops, snoops the CDB for
// pending operands and issues the oldest operand-ready entry.
module reservation_station #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = r2rv_pkg::TAG_W,
  parameter int unsigned OP_W  = r2rv_pkg::OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [31:0]      in_vj,
  input  logic [31:0]      in_vk,
  input  logic [TAG_W-1:0] in_qj,
  input  logic [TAG_W-1:0] in_qk,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_op,
  output logic [31:0]      out_vj,
  output logic [31:0]      out_vk,
  output logic [TAG_W-1:0] out_tag
);

  import r2rv_pkg::*;

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || TAG_W != r2rv_pkg::TAG_W || OP_W != r2rv_pkg::OP_W) begin : g_param_check
    $error("reservation_station: DEPTH must be >= 2 and widths must match r2rv_pkg");
  end

  rs_entry_t                  ent_q [DEPTH];
  rs_entry_t                  ent_d [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  logic                       hold_vld_q, hold_vld_d;
  logic [IDX_W-1:0]           hold_idx_q, hold_idx_d;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] grant;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  rs_entry_t        sel_ent;
  logic             fire;
  logic             dispatch;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy[i]  = ent_q[i].busy;
      ready[i] = ent_q[i].busy && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
    end
  end

  // Lowest-index free slot; in_ready uses registered busy only.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  assign in_ready = |(~busy);
  assign dispatch = in_valid && in_ready;

  rs_oldest_select #(
    .DEPTH (DEPTH)
  ) u_oldest_select (
    .ready (ready),
    .older (older_q),
    .grant (grant),
    .valid (grant_vld)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) grant_idx = grant_idx | IDX_W'(i);
    end
  end

  // A held selection stays put even if an older entry wakes meanwhile.
  assign sel_idx   = hold_vld_q ? hold_idx_q : grant_idx;
  assign sel_ent   = ent_q[sel_idx];
  assign out_valid = hold_vld_q || grant_vld;
  assign fire      = out_valid && out_ready;
  assign out_op    = out_valid ? sel_ent.op  : '0;
  assign out_vj    = out_valid ? sel_ent.vj  : '0;
  assign out_vk    = out_valid ? sel_ent.vk  : '0;
  assign out_tag   = out_valid ? sel_ent.tag : '0;

  always_comb begin
    ent_d      = ent_q;
    older_d    = older_q;
    hold_vld_d = hold_vld_q;
    hold_idx_d = hold_idx_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy) begin
        if (tag_hit(cdb_valid, ent_q[i].qj, cdb_tag)) begin
          ent_d[i].vj = cdb_value;
          ent_d[i].qj = '0;
        end
        if (tag_hit(cdb_valid, ent_q[i].qk, cdb_tag)) begin
          ent_d[i].vk = cdb_value;
          ent_d[i].qk = '0;
        end
      end
    end

    if (fire) begin
      ent_d[sel_idx].busy = 1'b0;
      hold_vld_d          = 1'b0;
    end else if (out_valid) begin
      hold_vld_d = 1'b1;
      hold_idx_d = sel_idx;
    end

    if (dispatch) begin
      ent_d[free_idx].busy = 1'b1;
      ent_d[free_idx].op   = in_op;
      ent_d[free_idx].tag  = in_tag;
      ent_d[free_idx].vj   = in_vj;
      ent_d[free_idx].qj   = in_qj;
      ent_d[free_idx].vk   = in_vk;
      ent_d[free_idx].qk   = in_qk;
      if (tag_hit(cdb_valid, in_qj, cdb_tag)) begin
        ent_d[free_idx].vj = cdb_value;
        ent_d[free_idx].qj = '0;
      end
      if (tag_hit(cdb_valid, in_qk, cdb_tag)) begin
        ent_d[free_idx].vk = cdb_value;
        ent_d[free_idx].qk = '0;
      end
      // New entry is younger than every currently busy entry.
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        older_d[j][free_idx] = busy[j];
      end
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].busy = 1'b0;
      end
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      older_q    <= '0;
      hold_vld_q <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      older_q    <= older_d;
      hold_vld_q <= hold_vld_d;
      hold_idx_q <= hold_idx_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue, wakeup, full, hold, forward, flush/reset.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready;
  logic [9:0]  in_op;
  logic [31:0] in_vj, in_vk;
  logic [4:0]  in_qj, in_qk, in_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        out_valid, out_ready;
  logic [9:0]  out_op;
  logic [31:0] out_vj, out_vk;
  logic [4:0]  out_tag;

  int n_cmp = 0;
  int n_err = 0;

  reservation_station #(
    .DEPTH (4),
    .TAG_W (5),
    .OP_W  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_vj     (in_vj),
    .in_vk     (in_vk),
    .in_qj     (in_qj),
    .in_qk     (in_qk),
    .in_tag    (in_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_vj    (out_vj),
    .out_vk    (out_vk),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic [9:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [4:0] qj, input logic [4:0] qk, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_vj    = vj;
    in_vk    = vk;
    in_qj    = qj;
    in_qk    = qk;
    in_tag   = tag;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] value);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = value;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_vj = '0; in_vk = '0; in_qj = '0; in_qk = '0; in_tag = '0;
    cdb_tag = '0; cdb_value = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_vj", out_vj, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Ready dispatch issues the next cycle.
    set_in(10'h015, 32'd5, 32'd7, 5'd0, 5'd0, 5'd3);
    tick(); idle();
    check("rdy_valid", 32'(out_valid), 32'd1);
    check("rdy_vj", out_vj, 32'd5);
    check("rdy_vk", out_vk, 32'd7);
    check("rdy_tag", 32'(out_tag), 32'd3);
    check("rdy_op", 32'(out_op), 32'h015);
    tick();
    check("rdy_done", 32'(out_valid), 32'd0);

    // Wakeup via CDB.
    set_in(10'h000, 32'd0, 32'd1, 5'd4, 5'd0, 5'd5);
    tick(); idle();
    check("wk_wait0", 32'(out_valid), 32'd0);
    tick();
    check("wk_wait1", 32'(out_valid), 32'd0);
    cdb(5'd4, 32'hDEAD);
    tick(); idle();
    check("wk_valid", 32'(out_valid), 32'd1);
    check("wk_vj", out_vj, 32'hDEAD);
    check("wk_tag", 32'(out_tag), 32'd5);
    tick();
    check("wk_done", 32'(out_valid), 32'd0);

    // Full: four waiting entries, fifth dispatch refused.
    for (int i = 0; i < 4; i++) begin
      set_in(10'h001, 32'(i), 32'd0, 5'd6, 5'd0, 5'(11 + i));
      tick();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    set_in(10'h002, 32'd0, 32'd99, 5'd0, 5'd0, 5'd15);
    tick(); idle();
    check("full_in_ready2", 32'(in_ready), 32'd0);
    check("full_no_issue", 32'(out_valid), 32'd0);
    cdb(5'd6, 32'h66);
    tick(); idle();
    check("full_iss0_tag", 32'(out_tag), 32'd11);
    check("full_iss0_vj", out_vj, 32'h66);
    check("full_iss0_inrdy", 32'(in_ready), 32'd0);
    tick();
    check("full_iss1_tag", 32'(out_tag), 32'd12);
    check("full_iss1_inrdy", 32'(in_ready), 32'd1);
    tick();
    check("full_iss2_tag", 32'(out_tag), 32'd13);
    tick();
    check("full_iss3_tag", 32'(out_tag), 32'd14);
    tick();
    check("full_drained", 32'(out_valid), 32'd0);

    // Hold stability: held B is not displaced by older A waking.
    out_ready = 1'b0;
    set_in(10'h003, 32'hA, 32'd0, 5'd2, 5'd0, 5'd7);
    tick();
    set_in(10'h004, 32'hB, 32'hBB, 5'd0, 5'd0, 5'd8);
    tick(); idle();
    check("hold_b_tag", 32'(out_tag), 32'd8);
    cdb(5'd2, 32'h22);
    tick(); idle();
    check("hold_b_tag2", 32'(out_tag), 32'd8);
    check("hold_b_vj", out_vj, 32'hB);
    tick();
    check("hold_b_tag3", 32'(out_tag), 32'd8);
    out_ready = 1'b1;
    tick();
    check("hold_a_tag", 32'(out_tag), 32'd7);
    check("hold_a_vj", out_vj, 32'h22);
    tick();
    check("hold_done", 32'(out_valid), 32'd0);

    // Same-cycle forward into the dispatched entry.
    set_in(10'h005, 32'd1, 32'd0, 5'd0, 5'd9, 5'd10);
    cdb(5'd9, 32'd11);
    tick(); idle();
    check("fwd_valid", 32'(out_valid), 32'd1);
    check("fwd_vk", out_vk, 32'd11);
    check("fwd_tag", 32'(out_tag), 32'd10);
    tick();
    check("fwd_done", 32'(out_valid), 32'd0);

    // Flush with three busy entries and a concurrent dispatch.
    for (int i = 0; i < 3; i++) begin
      set_in(10'h006, 32'd0, 32'd0, 5'd12, 5'd0, 5'(16 + i));
      tick();
    end
    set_in(10'h007, 32'd1, 32'd2, 5'd0, 5'd0, 5'd19);
    flush = 1'b1;
    tick(); idle();
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    cdb(5'd12, 32'h12);
    tick(); idle();
    check("fl_after_cdb", 32'(out_valid), 32'd0);
    tick();
    check("fl_after_cdb2", 32'(out_valid), 32'd0);

    // Same sequence with reset in place of flush.
    for (int i = 0; i < 3; i++) begin
      set_in(10'h006, 32'd0, 32'd0, 5'd12, 5'd0, 5'(16 + i));
      tick();
    end
    set_in(10'h007, 32'd1, 32'd2, 5'd0, 5'd0, 5'd19);
    reset = 1'b1;
    tick(); idle();
    reset = 1'b0;
    check("rs_in_ready", 32'(in_ready), 32'd1);
    check("rs_out_valid", 32'(out_valid), 32'd0);
    cdb(5'd12, 32'h12);
    tick(); idle();
    check("rs_after_cdb", 32'(out_valid), 32'd0);
    tick();
    check("rs_after_cdb2", 32'(out_valid), 32'd0);

    // Still functional after reset.
    set_in(10'h008, 32'd3, 32'd4, 5'd0, 5'd0, 5'd20);
    tick(); idle();
    check("post_tag", 32'(out_tag), 32'd20);
    check("post_vk", out_vk, 32'd4);
    tick();
    check("post_done", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
